sector_hexdump_tx: RTL and testbench
====================================

Name: sector_hexdump_tx

Overview:
Downstream consumer of the 512-byte sector SRAM that the SD card reader fills. On a start pulse it reads a byte range from the SRAM read port and formats it as an ASCII hex dump. The dump goes out through the existing uart transmitter's transmit / is_transmitting handshake. It is used as a debug and inspection path alongside the tag-search flow.

Parameters:
BYTES_PER_LINE, 16, data bytes printed per output line (1..32)
ADDR_W, 9, SRAM address width (512-byte sector)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  ADDR_W  first SRAM address to dump
length  input  10  byte count, 0..512; values above 512 are clamped to 512
mem_addr  output  ADDR_W  SRAM read address
mem_data  input  8  SRAM read data, valid the cycle after mem_addr is presented (registered read)
tx_byte  output  8  character to the UART
transmit  output  1  UART send request
is_transmitting  input  1  UART busy flag
busy  output  1  high from start acceptance until done
done  output  1  one-cycle pulse when the dump completes

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all outputs 0; all counters 0.
  - Reset asserted mid-dump aborts immediately.
  - No done pulse is issued for an aborted dump.
- Start:
  - IDLE + start=1: latch base_addr, latch clamped length, set byte index i=0, busy=1.
  - If the latched length is 0: go to FIN.
  - start while busy is ignored.
- Output format:
  - Each line begins with a prefix: 3 uppercase hex digits of the relative offset i, then ':' and ' '.
  - Each byte prints as 2 uppercase hex digits followed by ' '.
  - A line ends with "\r\n" (0x0D 0x0A) after BYTES_PER_LINE bytes, or after the final byte.
  - Hex encoding: nibble<10 maps to 0x30+n; otherwise 0x41+n-10.
- Addressing:
  - mem_addr = (base_addr + i) mod 2^ADDR_W, so reads wrap from 511 to 0.
  - The printed offset is i, not the SRAM address.
- States:
  - IDLE
  - FETCH: drive mem_addr.
  - LOAD: capture mem_data into a byte register on the next cycle.
  - CHAR: select the next character from the sub-index: prefix 0..4, hi, lo, space, CR, LF.
  - WAIT: transmit=1 and tx_byte held; leave when is_transmitting=1.
  - SEND: transmit=0; leave when is_transmitting=0.
  - NEXT: advance the sub-index, i, and the line position.
  - FIN
- Sequencing:
  - A new byte is fetched (FETCH/LOAD) only before its hi digit.
  - Prefix characters need no fetch.
  - tx_byte is stable from WAIT entry through SEND.
- Completion:
  - After the LF of the last line → FIN.
  - FIN: done=1 for exactly one cycle, busy=0, then IDLE.
  - A new start is accepted on the cycle after FIN.
- Latency:
  - Start accepted at cycle 0 → first transmit=1 no later than cycle 3.
  - Characters are strictly serialized; transmit is never asserted while is_transmitting=1 in SEND.
- Characters per full line: 5 + 3·BYTES_PER_LINE + 2, i.e. 55 with the default.
- Counter widths: i is 10 bits (reaches 512); the prefix uses i[8:0] formatted as 3 hex digits.
- length=512 with base_addr=0 prints offsets 000..1F0, 32 lines.

Test Plan:
- Single byte: base=0, length=1, SRAM[0]=0xA5 → chars "000: A5 \r\n" (10 bytes), then done pulse; busy low after.
- Full line: length=16, SRAM[k]=k → 55 chars "000: 00 01 … 0F \r\n"; length=17 adds "010: 10 \r\n".
- Wrap: base=510, length=4, SRAM[510,511,0,1]=0x11,0x22,0x33,0x44 → "000: 11 22 33 44 \r\n"; mem_addr sequence 510,511,0,1.
- Zero and clamp:
  - length=0 → transmit never asserted; done within 2 cycles of start.
  - length=700 → exactly 512 bytes dumped, last line prefix "1F0".
- Handshake: UART model holds is_transmitting high for varying 1..20 cycles → each char sent exactly once, no drops or duplicates; a start pulse mid-dump is ignored.
- Reset mid-dump: drive rst=0 during the 3rd char with no clock edge → outputs 0 immediately; after release, new start base=0 length=1 → a clean "000: …" line and no stale done pulse.

Source files
------------

// File: rtl/sector_hexdump_tx.sv
// ---------------------------------------------------------------------------
// sector_hexdump_tx
// Reads a byte range out of the 512-byte sector SRAM and streams it to the
// UART transmitter as an ASCII hex dump, one line per BYTES_PER_LINE bytes:
//     "OOO: HH HH ... HH \r\n"
// where OOO is the relative offset of the first byte on the line.
//
// Ports
//   clk             system clock
//   rst             asynchronous reset, active-low
//   start           one-cycle dump request, sampled only when idle
//   base_addr       first SRAM address of the dump
//   length          byte count 0..512 (larger values are clamped to 512)
//   mem_addr        SRAM read address (registered read, data next cycle)
//   mem_data        SRAM read data
//   tx_byte         character presented to the UART
//   transmit        UART send request
//   is_transmitting UART busy flag
//   busy            dump in progress
//   done            one-cycle pulse at dump completion
// ---------------------------------------------------------------------------
module sector_hexdump_tx #(
    parameter int BYTES_PER_LINE = 16,
    parameter int ADDR_W         = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [9:0]        length,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        tx_byte,
    output logic              transmit,
    input  logic              is_transmitting,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_CHAR  = 3'd3,
        S_WAIT  = 3'd4,
        S_SEND  = 3'd5,
        S_NEXT  = 3'd6,
        S_FIN   = 3'd7
    } state_t;

    localparam logic [5:0] LP_BPL = 6'(BYTES_PER_LINE);

    // Character sub-index within a line:
    // 0..2 offset digits, 3 ':', 4 ' ', 5 hi digit, 6 lo digit, 7 ' ', 8 CR, 9 LF
    localparam logic [3:0] SUB_SEP   = 4'd4;
    localparam logic [3:0] SUB_SPACE = 4'd7;
    localparam logic [3:0] SUB_LF    = 4'd9;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_base;
    logic [9:0]        r_len;
    logic [9:0]        r_i;
    logic [9:0]        w_i_nxt;
    logic [5:0]        r_pos;
    logic [3:0]        r_sub;
    logic [7:0]        r_byte;
    logic [7:0]        r_tx_byte;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_transmit;
    logic              r_busy;
    logic              r_done;
    logic [9:0]        w_len_clamped;
    logic              w_line_end;
    logic              w_dump_end;
    logic [7:0]        w_char;

    // Nibble to uppercase ASCII hex; 0x37 + n equals 'A' + (n - 10)
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end else begin
            return 8'h37 + {4'h0, n};
        end
    endfunction

    assign w_len_clamped = (length > 10'd512) ? 10'd512 : length;
    // Byte just printed is the last of its line (line full, or dump exhausted)
    assign w_line_end    = ((r_i + 10'd1) == r_len) || ((r_pos + 6'd1) == LP_BPL);
    // Evaluated at the LF: i has already been advanced past the last byte
    assign w_dump_end    = (r_i == r_len);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (w_len_clamped == 10'd0) ? S_FIN : S_CHAR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_CHAR;
            S_CHAR:  w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (is_transmitting) begin
                    w_state_nxt = S_SEND;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_SEND: begin
                if (!is_transmitting) begin
                    w_state_nxt = S_NEXT;
                end else begin
                    w_state_nxt = S_SEND;
                end
            end
            S_NEXT: begin
                case (r_sub)
                    SUB_SEP:   w_state_nxt = S_FETCH;
                    SUB_SPACE: w_state_nxt = w_line_end ? S_CHAR : S_FETCH;
                    SUB_LF:    w_state_nxt = w_dump_end ? S_FIN : S_CHAR;
                    default:   w_state_nxt = S_CHAR;
                endcase
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Byte index for the next cycle; the fetch address is derived from it
    always_comb begin
        w_i_nxt = r_i;
        if ((r_state == S_IDLE) && start) begin
            w_i_nxt = 10'd0;
        end else if ((r_state == S_NEXT) && (r_sub == SUB_SPACE)) begin
            w_i_nxt = r_i + 10'd1;
        end else begin
            w_i_nxt = r_i;
        end
    end

    // Character selection from the sub-index
    always_comb begin
        w_char = 8'h00;
        case (r_sub)
            4'd0:    w_char = hex_char({3'b000, r_i[8]});
            4'd1:    w_char = hex_char(r_i[7:4]);
            4'd2:    w_char = hex_char(r_i[3:0]);
            4'd3:    w_char = 8'h3A;
            4'd4:    w_char = 8'h20;
            4'd5:    w_char = hex_char(r_byte[7:4]);
            4'd6:    w_char = hex_char(r_byte[3:0]);
            4'd7:    w_char = 8'h20;
            4'd8:    w_char = 8'h0D;
            4'd9:    w_char = 8'h0A;
            default: w_char = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dump context, line position, sub-index and fetched byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base <= '0;
            r_len  <= 10'd0;
            r_i    <= 10'd0;
            r_pos  <= 6'd0;
            r_sub  <= 4'd0;
            r_byte <= 8'h00;
        end else begin
            r_i <= w_i_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base <= base_addr;
                        r_len  <= w_len_clamped;
                        r_pos  <= 6'd0;
                        r_sub  <= 4'd0;
                    end
                end
                S_LOAD: r_byte <= mem_data;
                S_NEXT: begin
                    case (r_sub)
                        SUB_SPACE: begin
                            r_pos <= r_pos + 6'd1;
                            r_sub <= w_line_end ? 4'd8 : 4'd5;
                        end
                        SUB_LF: begin
                            r_pos <= 6'd0;
                            r_sub <= 4'd0;
                        end
                        default: r_sub <= r_sub + 4'd1;
                    endcase
                end
                default: r_byte <= r_byte;
            endcase
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr <= '0;
            r_tx_byte  <= 8'h00;
            r_transmit <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_state_nxt == S_FETCH) begin
                // Address wraps naturally at 2^ADDR_W
                r_mem_addr <= r_base + w_i_nxt[ADDR_W-1:0];
            end
            if (r_state == S_CHAR) begin
                r_tx_byte <= w_char;
            end
            r_transmit <= (w_state_nxt == S_WAIT);
            r_busy     <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
            r_done     <= (w_state_nxt == S_FIN);
        end
    end

    assign mem_addr = r_mem_addr;
    assign tx_byte  = r_tx_byte;
    assign transmit = r_transmit;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_sector_hexdump_tx.sv
// ---------------------------------------------------------------------------
// Scoreboard bench for sector_hexdump_tx: the expected character stream is
// built from the SRAM model when a dump is started, and each character the
// UART model accepts is popped and compared.
// ---------------------------------------------------------------------------
module tb_sector_hexdump_tx;

    localparam int BPL = 16;
    localparam int AW  = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [9:0]    length;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [7:0]    tx_byte;
    logic          transmit;
    logic          is_transmitting;
    logic          busy;
    logic          done;

    logic [7:0] sram [0:511];
    logic [7:0] exp_q[$];
    int         addr_log[$];

    int n_checks = 0;
    int n_fail   = 0;
    int uart_cnt = 0;
    int n_got;
    int n_extra;
    int n_dup;
    int lat;

    sector_hexdump_tx #(
        .BYTES_PER_LINE(BPL),
        .ADDR_W(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .tx_byte(tx_byte),
        .transmit(transmit),
        .is_transmitting(is_transmitting),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // SRAM model with registered read
    always @(posedge clk) mem_data <= sram[mem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hex_ascii(input int n);
        string digits;
        digits = "0123456789ABCDEF";
        return 8'(digits.getc(n));
    endfunction

    task automatic push_expected(input int base, input int len);
        int n;
        logic [7:0] d;
        n = (len > 512) ? 512 : len;
        for (int i = 0; i < n; i++) begin
            if ((i % BPL) == 0) begin
                exp_q.push_back(hex_ascii((i >> 8) & 15));
                exp_q.push_back(hex_ascii((i >> 4) & 15));
                exp_q.push_back(hex_ascii(i & 15));
                exp_q.push_back(8'h3A);
                exp_q.push_back(8'h20);
            end
            d = sram[(base + i) % 512];
            exp_q.push_back(hex_ascii(int'(d[7:4])));
            exp_q.push_back(hex_ascii(int'(d[3:0])));
            exp_q.push_back(8'h20);
            if (((i % BPL) == BPL - 1) || (i == n - 1)) begin
                exp_q.push_back(8'h0D);
                exp_q.push_back(8'h0A);
            end
        end
    endtask

    // Start a dump and act as the UART until done (or stop_after chars seen)
    task automatic run_dump(input int base, input int len, input int max_d,
                            input bit poke_start, input int stop_after, output int lat_done);
        int budget;
        bit seen_done;
        logic [AW-1:0] last_addr;
        push_expected(base, len);
        n_got = 0; n_extra = 0; n_dup = 0; uart_cnt = 0;
        is_transmitting = 1'b0;
        addr_log.delete();
        lat_done = -1;
        seen_done = 1'b0;
        budget = 200 + exp_q.size() * (max_d + 10);
        @(negedge clk);
        base_addr = base[AW-1:0];
        length    = len[9:0];
        start     = 1'b1;
        last_addr = mem_addr;
        for (int cyc = 1; cyc <= budget && !seen_done; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (poke_start && cyc == 30) begin
                base_addr = 9'd100;
                length    = 10'd3;
                start     = 1'b1;
            end
            if (mem_addr != last_addr) begin
                addr_log.push_back(int'(mem_addr));
                last_addr = mem_addr;
            end
            if (done) begin
                seen_done = 1'b1;
                lat_done  = cyc;
                check_val("busy_at_done", busy, 0);
            end
            if (uart_cnt > 0) begin
                if (transmit) n_dup++;
                uart_cnt--;
                if (uart_cnt == 0) is_transmitting = 1'b0;
            end else if (transmit) begin
                if (exp_q.size() > 0) check_val("char", tx_byte, exp_q.pop_front());
                else n_extra++;
                n_got++;
                uart_cnt = $urandom_range(max_d, 1);
                is_transmitting = 1'b1;
                if (stop_after != 0 && n_got == stop_after) return;
            end
        end
        check_val("done_seen", seen_done, 1);
        @(negedge clk);
        check_val("done_one_cycle", done, 0);
        check_val("busy_after_done", busy, 0);
        check_val("chars_missing", exp_q.size(), 0);
        check_val("chars_extra", n_extra, 0);
        check_val("tx_while_busy", n_dup, 0);
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; base_addr = '0; length = 10'd0; is_transmitting = 1'b0;
        for (int k = 0; k < 512; k++) sram[k] = 8'(k);
        repeat (3) @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_transmit", transmit, 0);
        check_val("rst_tx_byte", tx_byte, 0);
        check_val("rst_mem_addr", mem_addr, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single byte
        sram[0] = 8'hA5;
        run_dump(0, 1, 4, 1'b0, 0, lat);
        check_val("single_count", n_got, 10);
        sram[0] = 8'h00;

        // Full line, then one line plus one byte with slow UART and a stray start
        run_dump(0, 16, 3, 1'b0, 0, lat);
        check_val("line16_count", n_got, 55);
        run_dump(0, 17, 20, 1'b1, 0, lat);
        check_val("line17_count", n_got, 65);

        // Address wrap
        sram[510] = 8'h11; sram[511] = 8'h22; sram[0] = 8'h33; sram[1] = 8'h44;
        run_dump(510, 4, 5, 1'b0, 0, lat);
        check_val("wrap_count", n_got, 19);
        check_val("wrap_addr_n", addr_log.size(), 4);
        if (addr_log.size() == 4) begin
            check_val("wrap_addr0", addr_log[0], 510);
            check_val("wrap_addr1", addr_log[1], 511);
            check_val("wrap_addr2", addr_log[2], 0);
            check_val("wrap_addr3", addr_log[3], 1);
        end

        // Zero length
        run_dump(0, 0, 2, 1'b0, 0, lat);
        check_val("zero_no_tx", n_got, 0);
        check_val("zero_done_lat", (lat >= 1 && lat <= 2), 1);

        // Length clamp: 512 bytes, 32 lines, last prefix 1F0
        for (int k = 0; k < 512; k++) sram[k] = 8'($urandom_range(255, 0));
        run_dump(0, 700, 2, 1'b0, 0, lat);
        check_val("clamp_count", n_got, 32 * 55);

        // Reset during the third character
        run_dump(0, 16, 3, 1'b0, 3, lat);
        #2 rst = 1'b0;
        #1;
        check_val("abort_transmit", transmit, 0);
        check_val("abort_busy", busy, 0);
        check_val("abort_done", done, 0);
        check_val("abort_tx_byte", tx_byte, 0);
        check_val("abort_mem_addr", mem_addr, 0);
        exp_q.delete();
        is_transmitting = 1'b0;
        uart_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_val("no_stale_done", done, 0);
        end
        run_dump(0, 1, 3, 1'b0, 0, lat);
        check_val("post_reset_count", n_got, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
